// File: rtl/mmu_read_arbiter.sv
// Shares the single AXI read channel between the MMU instruction and data fetch controllers.
// One owned transaction at a time: grant in IDLE, hold AR until accepted, route R beats to the owner until rlast.
module mmu_read_arbiter #(
    parameter int BURST_LEN    = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_single,
    output logic        i_req_ok,
    output logic        i_rvalid,
    output logic        i_rlast,
    output logic        i_rerr,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_single,
    input  logic [2:0]  d_size,
    output logic        d_req_ok,
    output logic        d_rvalid,
    output logic        d_rlast,
    output logic        d_rerr,
    output logic [31:0] r_data,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    // state  | meaning
    // S_IDLE | no transaction owned; arbitrate and latch AR fields on any request
    // S_ADDR | arvalid held with stable AR fields until arready
    // S_DATA | rready high; beats routed to owner until rvalid && rlast

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    localparam int              CW        = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0]   LIMIT     = CW'(STARVE_LIMIT);
    localparam logic [7:0]      BURST_ARL = 8'(BURST_LEN - 1);

    state_t        state, state_nxt;
    logic          owner_inst;
    logic [CW-1:0] starve_cnt;
    logic          grant_inst;
    logic          grant_single;
    logic          beat;

    // Data wins conflicts unless inst has already been passed over STARVE_LIMIT times.
    assign grant_inst   = i_req && (!d_req || (starve_cnt == LIMIT));
    assign grant_single = grant_inst ? i_single : d_single;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (i_req || d_req)      state_nxt = S_ADDR;
            S_ADDR: if (arready)             state_nxt = S_DATA;
            S_DATA: if (rvalid && rlast)     state_nxt = S_IDLE;
            default:                         state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_inst <= 1'b1;
            starve_cnt <= '0;
            araddr     <= '0;
            arlen      <= '0;
            arsize     <= '0;
            arburst    <= '0;
        end else if (state == S_IDLE && (i_req || d_req)) begin
            owner_inst <= grant_inst;
            araddr     <= grant_inst ? i_addr : d_addr;
            arlen      <= grant_single ? 8'd0 : BURST_ARL;
            arburst    <= grant_single ? 2'd0 : 2'd1;
            arsize     <= (!grant_inst && d_single) ? d_size : 3'b010;
            if (grant_inst || !i_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        arvalid  = (state == S_ADDR);
        rready   = (state == S_DATA);
        i_req_ok = arvalid && arready && owner_inst;
        d_req_ok = arvalid && arready && !owner_inst;
        beat     = rready && rvalid;
        i_rvalid = beat && owner_inst;
        i_rlast  = beat && owner_inst && rlast;
        i_rerr   = beat && owner_inst && (rresp != 2'b00);
        d_rvalid = beat && !owner_inst;
        d_rlast  = beat && !owner_inst && rlast;
        d_rerr   = beat && !owner_inst && (rresp != 2'b00);
    end

    assign r_data = rdata;

endmodule

// File: tb/tb_mmu_read_arbiter.sv
// Directed bench for mmu_read_arbiter: per-cycle vector table plus hand-written
// sequences for starvation ordering and reset in the middle of a burst.
module tb_mmu_read_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req, i_single, d_req, d_single;
    logic [31:0] i_addr, d_addr;
    logic [2:0]  d_size;
    logic        i_req_ok, i_rvalid, i_rlast, i_rerr;
    logic        d_req_ok, d_rvalid, d_rlast, d_rerr;
    logic [31:0] r_data, araddr, rdata;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp;
    logic        arvalid, arready, rlast, rvalid, rready;

    always #5 clk = ~clk;

    mmu_read_arbiter #(.BURST_LEN(16), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_single(i_single), .i_req_ok(i_req_ok),
        .i_rvalid(i_rvalid), .i_rlast(i_rlast), .i_rerr(i_rerr),
        .d_req(d_req), .d_addr(d_addr), .d_single(d_single), .d_size(d_size),
        .d_req_ok(d_req_ok), .d_rvalid(d_rvalid), .d_rlast(d_rlast), .d_rerr(d_rerr),
        .r_data(r_data), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    // ctl = {arvalid, rready, i_req_ok, d_req_ok, i_rvalid, i_rlast, i_rerr, d_rvalid, d_rlast, d_rerr}
    localparam logic [9:0] AV  = 10'b10_0000_0000;
    localparam logic [9:0] RR  = 10'b01_0000_0000;
    localparam logic [9:0] IOK = 10'b00_1000_0000;
    localparam logic [9:0] DOK = 10'b00_0100_0000;
    localparam logic [9:0] IRV = 10'b00_0010_0000;
    localparam logic [9:0] IRL = 10'b00_0001_0000;
    localparam logic [9:0] IRE = 10'b00_0000_1000;
    localparam logic [9:0] DRV = 10'b00_0000_0100;
    localparam logic [9:0] DRL = 10'b00_0000_0010;
    localparam logic [9:0] DRE = 10'b00_0000_0001;

    typedef struct {
        logic        i_req, i_single, d_req, d_single, arready, rvalid, rlast;
        logic [31:0] i_addr, d_addr, rdata;
        logic [2:0]  d_size;
        logic [1:0]  rresp;
        logic [9:0]  exp_ctl;
        logic        chk_ar, chk_rd;
        logic [44:0] exp_ar;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [9:0] ctl();
        return {arvalid, rready, i_req_ok, d_req_ok, i_rvalid, i_rlast, i_rerr, d_rvalid, d_rlast, d_rerr};
    endfunction

    function automatic logic [44:0] ar();
        return {araddr, arlen, arsize, arburst};
    endfunction

    function automatic logic [44:0] mk_ar(logic [31:0] a, logic [7:0] l, logic [2:0] s, logic [1:0] b);
        return {a, l, s, b};
    endfunction

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        i_req = v.i_req; i_addr = v.i_addr; i_single = v.i_single;
        d_req = v.d_req; d_addr = v.d_addr; d_single = v.d_single; d_size = v.d_size;
        arready = v.arready; rvalid = v.rvalid; rlast = v.rlast; rresp = v.rresp; rdata = v.rdata;
    endtask

    task automatic clear_inputs();
        vec_t z;
        z = '{default: '0};
        drive(z);
    endtask

    task automatic build_table();
        vec_t v;
        // 1: data single-beat read
        v = '{default: '0};
        v.d_req = 1; v.d_addr = 32'h1FC0_0100; v.d_single = 1; v.d_size = 3'b000; v.arready = 1;
        v.chk_ar = 1; v.exp_ar = '0; vecs.push_back(v);
        v.exp_ctl = AV | DOK; v.exp_ar = mk_ar(32'h1FC0_0100, 8'd0, 3'd0, 2'd0); vecs.push_back(v);
        v = '{default: '0};
        v.arready = 1; v.rvalid = 1; v.rlast = 1; v.rdata = 32'hDEAD_BEEF;
        v.exp_ctl = RR | DRV | DRL; v.chk_rd = 1; v.exp_rd = 32'hDEAD_BEEF; vecs.push_back(v);
        v = '{default: '0}; vecs.push_back(v);

        // 2: inst 16-beat burst, data request arriving during the last beat must wait
        v = '{default: '0};
        v.i_req = 1; v.i_addr = 32'hBFC0_0000; v.i_single = 0; v.arready = 1; vecs.push_back(v);
        v.exp_ctl = AV | IOK; v.chk_ar = 1; v.exp_ar = mk_ar(32'hBFC0_0000, 8'd15, 3'd2, 2'd1);
        vecs.push_back(v);
        for (int k = 0; k < 16; k++) begin
            v = '{default: '0};
            v.arready = 1; v.rvalid = 1; v.rlast = (k == 15); v.rdata = 32'h0000_1000 + k;
            v.exp_ctl = RR | IRV | ((k == 15) ? IRL : 10'd0); v.chk_rd = 1; v.exp_rd = v.rdata;
            if (k == 15) begin
                v.d_req = 1; v.d_addr = 32'h0000_0040; v.d_single = 1; v.d_size = 3'b001;
            end
            vecs.push_back(v);
            if (k == 8) begin
                v = '{default: '0}; v.arready = 1; v.exp_ctl = RR; vecs.push_back(v);
            end
        end
        v = '{default: '0};
        v.d_req = 1; v.d_addr = 32'h0000_0040; v.d_single = 1; v.d_size = 3'b001; v.arready = 1;
        vecs.push_back(v);
        v.exp_ctl = AV | DOK; v.chk_ar = 1; v.exp_ar = mk_ar(32'h0000_0040, 8'd0, 3'd1, 2'd0);
        vecs.push_back(v);
        v = '{default: '0};
        v.arready = 1; v.rvalid = 1; v.rlast = 1; v.rresp = 2'b11; v.rdata = 32'h0BAD_0BAD;
        v.exp_ctl = RR | DRV | DRL | DRE; vecs.push_back(v);
        v = '{default: '0}; vecs.push_back(v);

        // 4: arready held low for 5 cycles in ADDR
        v = '{default: '0};
        v.i_req = 1; v.i_addr = 32'h0000_4000; v.i_single = 0; v.arready = 0; vecs.push_back(v);
        for (int k = 0; k < 6; k++) begin
            v.arready = (k == 5);
            v.exp_ctl = AV | ((k == 5) ? IOK : 10'd0);
            v.chk_ar = 1; v.exp_ar = mk_ar(32'h0000_4000, 8'd15, 3'd2, 2'd1);
            vecs.push_back(v);
        end
        v = '{default: '0};
        v.rvalid = 1; v.rlast = 1; v.exp_ctl = RR | IRV | IRL; vecs.push_back(v);
        v = '{default: '0}; vecs.push_back(v);

        // 5: error response on beat 3 of a data burst
        v = '{default: '0};
        v.d_req = 1; v.d_addr = 32'h0000_2000; v.d_single = 0; v.arready = 1; vecs.push_back(v);
        v.exp_ctl = AV | DOK; v.chk_ar = 1; v.exp_ar = mk_ar(32'h0000_2000, 8'd15, 3'd2, 2'd1);
        vecs.push_back(v);
        for (int k = 0; k < 16; k++) begin
            v = '{default: '0};
            v.rvalid = 1; v.rlast = (k == 15); v.rresp = (k == 2) ? 2'b10 : 2'b00;
            v.exp_ctl = RR | DRV | ((k == 2) ? DRE : 10'd0) | ((k == 15) ? DRL : 10'd0);
            vecs.push_back(v);
        end
        v = '{default: '0}; vecs.push_back(v);
    endtask

    initial begin
        logic [9:0] exp_order;
        int         ng;
        int         cyc;

        build_table();
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        cmp("reset_ctl", ctl(), '0);
        cmp("reset_ar", ar(), '0);
        rst = 1'b1;

        for (int n = 0; n < vecs.size(); n++) begin
            drive(vecs[n]);
            @(negedge clk);
            cmp($sformatf("vec%0d_ctl", n), ctl(), vecs[n].exp_ctl);
            if (vecs[n].chk_ar) cmp($sformatf("vec%0d_ar", n), ar(), vecs[n].exp_ar);
            if (vecs[n].chk_rd) cmp($sformatf("vec%0d_rdata", n), r_data, vecs[n].exp_rd);
            @(posedge clk);
            #1;
        end

        // 3: both requesting continuously -> D,D,D,D,I,D,D,D,D,I
        exp_order = 10'b10_0001_0000;
        i_req = 1; i_addr = 32'h0000_0100; i_single = 1;
        d_req = 1; d_addr = 32'h0000_0200; d_single = 1; d_size = 3'b010;
        arready = 1; rvalid = 1; rlast = 1;
        ng = 0;
        cyc = 0;
        while (ng < 10 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (i_req_ok || d_req_ok) begin
                cmp($sformatf("grant%0d_inst", ng), i_req_ok, exp_order[ng]);
                ng++;
            end
        end
        if (ng < 10) cmp("grant_timeout", ng, 10);
        i_req = 0; d_req = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        cmp("post_starve_idle", ctl(), '0);
        @(posedge clk); #1;

        // 6: reset asserted during beat 7 of a data burst
        d_req = 1; d_addr = 32'h0000_3000; d_single = 0; arready = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        d_req = 0; rvalid = 1;
        for (int k = 1; k <= 6; k++) begin
            rdata = 32'h0000_3000 + k;
            @(posedge clk); #1;
        end
        rdata = 32'h0000_3007;
        #1;
        cmp("beat7_before_rst", ctl(), RR | DRV);
        rst = 1'b0;
        #1;
        cmp("async_rst_ctl", ctl(), '0);
        cmp("async_rst_ar", ar(), '0);
        @(posedge clk); #1;
        rvalid = 0;
        rst = 1'b1;
        d_req = 1; d_addr = 32'h1234_5670; d_single = 1; d_size = 3'b001;
        @(negedge clk);
        cmp("after_rst_idle", ctl(), '0);
        @(posedge clk); #1;
        @(negedge clk);
        cmp("after_rst_addr_ctl", ctl(), AV | DOK);
        cmp("after_rst_addr_ar", ar(), mk_ar(32'h1234_5670, 8'd0, 3'd1, 2'd0));
        @(posedge clk); #1;
        d_req = 0; rvalid = 1; rlast = 1;
        @(negedge clk);
        cmp("after_rst_beat", ctl(), RR | DRV | DRL);
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        cmp("final_idle", ctl(), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
